// File: rtl/rgb_fade_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | rgb_fade_pkg                                                           |
// | Shared types and helpers for the multi-channel fade/PWM generator.     |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
package rgb_fade_pkg;

   // Run-time operating mode, sampled once per PWM period
   typedef enum logic [1:0] {
      OFF    = 2'd0,
      SYNC   = 2'd1,
      PHASED = 2'd2,
      STATIC = 2'd3
   } mode_t;

   // Direction of the triangle fade for one channel
   typedef enum logic {
      UP   = 1'b0,
      DOWN = 1'b1
   } dir_t;

   // Bits needed to hold a duty value from 0 up to and including the interval
   function automatic int duty_width(input int interval);
      return $clog2(interval + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fade_channel.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fade_channel                                                           |
// | Triangle fade level/direction state for one PWM channel. level_o is    |
// | the level after this cycle's step or load, so the parent can latch a   |
// | duty derived from it in the same cycle the step happens.               |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module fade_channel
   import rgb_fade_pkg::*;
#(
   parameter int NUM_STEPS = 100,
   parameter int LW        = $clog2(NUM_STEPS + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          step_i,
   input  logic          load_i,
   input  logic [LW-1:0] load_level_i,
   input  dir_t          load_dir_i,
   output logic [LW-1:0] level_o
);

   logic [LW-1:0] level_q, level_d;
   dir_t          dir_q, dir_d;

   // Next level/direction: a load wins over a step; endpoints flip direction
   // on arrival so each endpoint is held for exactly one step
   always_comb begin
      level_d = level_q;
      dir_d   = dir_q;
      if (load_i) begin
         level_d = load_level_i;
         dir_d   = load_dir_i;
      end else if (step_i) begin
         if (dir_q == UP) begin
            level_d = level_q + LW'(1);
            if (level_q == LW'(NUM_STEPS - 1)) begin
               dir_d = DOWN;
            end
         end else begin
            level_d = level_q - LW'(1);
            if (level_q == LW'(1)) begin
               dir_d = UP;
            end
         end
      end
   end

   // Level and direction registers
   always_ff @(posedge clk) begin
      if (reset) begin
         level_q <= '0;
         dir_q   <= UP;
      end else begin
         level_q <= level_d;
         dir_q   <= dir_d;
      end
   end

   assign level_o = level_d;

endmodule
`default_nettype wire

// File: rtl/rgb_fade_pwm.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | rgb_fade_pwm                                                           |
// | NUM_CH PWM outputs from one shared period counter. Each channel's duty |
// | comes from a triangle fade (all in step, or phase-offset for colour    |
// | cycling) or from a static input. Duty is latched only at the period    |
// | boundary so outputs never glitch mid-period.                           |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module rgb_fade_pwm
   import rgb_fade_pkg::*;
#(
   parameter int NUM_CH       = 3,
   parameter int PWM_INTERVAL = 1200,
   parameter int NUM_STEPS    = 100,
   parameter int STEP_PERIODS = 50,
   parameter bit ACTIVE_LOW   = 1'b1
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic                                        enable,
   input  logic [1:0]                                  mode,
   input  logic [NUM_CH*duty_width(PWM_INTERVAL)-1:0]  static_duty,
   output logic [NUM_CH-1:0]                           pwm_out,
   output logic                                        period_start
);

   localparam int DW   = duty_width(PWM_INTERVAL);
   localparam int LW   = $clog2(NUM_STEPS + 1);
   localparam int SW   = $clog2(STEP_PERIODS + 1);
   localparam int UNIT = PWM_INTERVAL / NUM_STEPS;

   logic [DW-1:0]             cnt_q, cnt_d;
   logic [SW-1:0]             step_cnt_q, step_cnt_d;
   mode_t                     mode_q, mode_d;
   logic [DW-1:0]             duty_q [NUM_CH];
   logic [DW-1:0]             duty_d [NUM_CH];
   logic [NUM_CH-1:0]         raw_q, raw_d;
   logic                      period_start_q, period_start_d;

   mode_t                     mode_in;
   logic                      at_last;
   logic                      boundary;
   logic                      mode_change;
   logic                      fading_q;
   logic                      step_wrap;
   logic                      fade_step;
   logic                      fade_load;
   logic [LW-1:0]             level_nxt [NUM_CH];

   assign mode_in     = mode_t'(mode);
   assign at_last     = (cnt_q == DW'(PWM_INTERVAL - 1));
   assign boundary    = enable && at_last;
   assign mode_change = (mode_in != mode_q);
   assign fading_q    = (mode_q == SYNC) || (mode_q == PHASED);
   assign step_wrap   = (step_cnt_q == SW'(STEP_PERIODS - 1));
   assign fade_step   = boundary && !mode_change && fading_q && step_wrap;
   assign fade_load   = boundary && mode_change &&
                        ((mode_in == SYNC) || (mode_in == PHASED));

   // Per-channel fade state; PHASED spreads channels evenly round the
   // 2*NUM_STEPS-step triangle, SYNC starts them all at zero
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      localparam int   POS       = (i * 2 * NUM_STEPS) / NUM_CH;
      localparam int   PH_LEVEL  = (POS <= NUM_STEPS) ? POS : (2 * NUM_STEPS - POS);
      localparam dir_t PH_DIR    = (POS >= NUM_STEPS) ? DOWN : UP;

      logic [LW-1:0] load_level;
      dir_t          load_dir;

      assign load_level = (mode_in == PHASED) ? LW'(PH_LEVEL) : '0;
      assign load_dir   = (mode_in == PHASED) ? PH_DIR : UP;

      fade_channel #(
         .NUM_STEPS (NUM_STEPS),
         .LW        (LW)
      ) u_fade (
         .clk          (clk),
         .reset        (reset),
         .step_i       (fade_step),
         .load_i       (fade_load),
         .load_level_i (load_level),
         .load_dir_i   (load_dir),
         .level_o      (level_nxt[i])
      );
   end

   // Period counter, fade step prescaler and mode sampling
   always_comb begin
      cnt_d      = cnt_q;
      step_cnt_d = step_cnt_q;
      mode_d     = mode_q;
      if (enable) begin
         cnt_d = at_last ? '0 : cnt_q + DW'(1);
      end
      if (boundary) begin
         mode_d = mode_in;
         if (mode_change) begin
            step_cnt_d = '0;
         end else if (fading_q) begin
            step_cnt_d = step_wrap ? '0 : step_cnt_q + SW'(1);
         end
      end
   end

   // Duty latch at the boundary, using the freshly sampled mode and the
   // post-step (or freshly loaded) fade level
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         duty_d[i] = duty_q[i];
         if (boundary) begin
            case (mode_in)
               OFF:          duty_d[i] = '0;
               SYNC, PHASED: duty_d[i] = DW'(32'(level_nxt[i]) * UNIT);
               default: begin
                  if (static_duty[i*DW +: DW] > DW'(PWM_INTERVAL)) begin
                     duty_d[i] = DW'(PWM_INTERVAL);
                  end else begin
                     duty_d[i] = static_duty[i*DW +: DW];
                  end
               end
            endcase
         end
      end
   end

   // PWM compare and period marker, both one cycle behind cnt
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         raw_d[i] = enable && (cnt_q < duty_q[i]);
      end
      period_start_d = enable && (cnt_q == '0);
   end

   // State registers
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q          <= '0;
         step_cnt_q     <= '0;
         mode_q         <= OFF;
         raw_q          <= '0;
         period_start_q <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            duty_q[i] <= '0;
         end
      end else begin
         cnt_q          <= cnt_d;
         step_cnt_q     <= step_cnt_d;
         mode_q         <= mode_d;
         raw_q          <= raw_d;
         period_start_q <= period_start_d;
         for (int i = 0; i < NUM_CH; i++) begin
            duty_q[i] <= duty_d[i];
         end
      end
   end

   assign pwm_out      = raw_q ^ {NUM_CH{ACTIVE_LOW}};
   assign period_start = period_start_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb_fade_pwm.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_rgb_fade_pwm                                                        |
// | Self-checking bench: 12-cycle period, 4 fade steps, 2 periods/step,    |
// | 3 active-low channels. Per-period low-cycle counts are compared with   |
// | hand-computed duties.                                                  |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_rgb_fade_pwm;

   localparam int NUM_CH       = 3;
   localparam int PWM_INTERVAL = 12;
   localparam int NUM_STEPS    = 4;
   localparam int STEP_PERIODS = 2;
   localparam int DW           = 4;
   localparam int UNIT         = PWM_INTERVAL / NUM_STEPS;

   localparam logic [1:0] M_OFF    = 2'd0;
   localparam logic [1:0] M_SYNC   = 2'd1;
   localparam logic [1:0] M_PHASED = 2'd2;
   localparam logic [1:0] M_STATIC = 2'd3;

   logic                     clk = 1'b0;
   logic                     reset;
   logic                     enable;
   logic [1:0]               mode;
   logic [NUM_CH*DW-1:0]     static_duty;
   logic [NUM_CH-1:0]        pwm_out;
   logic                     period_start;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      string      name;
      logic [1:0] mode;
      logic [11:0] sd;
      int         e0;
      int         e1;
      int         e2;
   } vec_t;

   vec_t vecs [5];

   always #5 clk = ~clk;

   rgb_fade_pwm #(
      .NUM_CH       (NUM_CH),
      .PWM_INTERVAL (PWM_INTERVAL),
      .NUM_STEPS    (NUM_STEPS),
      .STEP_PERIODS (STEP_PERIODS),
      .ACTIVE_LOW   (1'b1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .mode         (mode),
      .static_duty  (static_duty),
      .pwm_out      (pwm_out),
      .period_start (period_start)
   );

   task automatic check(input string name, input bit ok, input int act, input int req);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   // Bounded wait until period_start is seen high at a falling edge
   task automatic wait_start(input string name, output bit ok);
      int waited = 0;
      while (period_start !== 1'b1 && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      ok = (period_start === 1'b1);
      if (!ok) check({name, " period_start timeout"}, 1'b0, 0, 1);
   endtask

   // Observe one full period; optionally change mode/static inputs after sample chg_at
   task automatic measure(input string name, input bit do_check,
                          input int e0, input int e1, input int e2,
                          input int chg_at, input logic [1:0] chg_mode,
                          input logic [11:0] chg_sd);
      int low [3];
      bit contig [3];
      bit seen_hi [3];
      int exp_d [3];
      bit ps_ok;
      bit ok;
      exp_d = '{e0, e1, e2};
      wait_start(name, ok);
      if (!ok) return;
      ps_ok = 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
         low[c] = 0; contig[c] = 1'b1; seen_hi[c] = 1'b0;
      end
      for (int k = 0; k < PWM_INTERVAL; k++) begin
         if (k > 0) @(negedge clk);
         for (int c = 0; c < NUM_CH; c++) begin
            if (pwm_out[c] === 1'b0) begin
               low[c]++;
               if (seen_hi[c]) contig[c] = 1'b0;
            end else begin
               seen_hi[c] = 1'b1;
            end
         end
         if (period_start !== (k == 0)) ps_ok = 1'b0;
         if (k == chg_at) begin
            mode        = chg_mode;
            static_duty = chg_sd;
         end
      end
      if (do_check) begin
         for (int c = 0; c < NUM_CH; c++) begin
            check($sformatf("%s ch%0d low cycles (contiguous=%0b)", name, c, contig[c]),
                  (low[c] == exp_d[c]) && contig[c], low[c], exp_d[c]);
         end
         check({name, " period_start single pulse"}, ps_ok, int'(ps_ok), 1);
      end
   endtask

   initial begin : main
      int lows [3];
      int bad;
      int s, pos, lvl, d;
      bit ok;

      vecs[0] = '{"off",           M_OFF,    {4'd0,  4'd0, 4'd0},  0,  0,  0};
      vecs[1] = '{"static 0/5/12", M_STATIC, {4'd12, 4'd5, 4'd0},  0,  5, 12};
      vecs[2] = '{"static clamp",  M_STATIC, {4'd15, 4'd1, 4'd11}, 11, 1, 12};
      vecs[3] = '{"static 7/12/3", M_STATIC, {4'd3,  4'd12, 4'd7}, 7, 12,  3};
      vecs[4] = '{"off again",     M_OFF,    {4'd0,  4'd0, 4'd0},  0,  0,  0};

      // Reset and OFF behaviour
      reset = 1'b1; enable = 1'b1; mode = M_OFF; static_duty = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset pwm_out", pwm_out === 3'b111, int'(pwm_out), 7);
      check("reset period_start", period_start === 1'b0, int'(period_start), 0);
      reset = 1'b0;
      @(negedge clk);
      check("first period_start after reset", period_start === 1'b1, int'(period_start), 1);
      measure("off p0", 1'b1, 0, 0, 0, -1, M_OFF, '0);
      measure("off p1", 1'b1, 0, 0, 0, -1, M_OFF, '0);

      // Table: mode/static change takes effect from the period after next
      for (int v = 0; v < 5; v++) begin
         mode = vecs[v].mode;
         static_duty = vecs[v].sd;
         measure({vecs[v].name, " settle"}, 1'b0, 0, 0, 0, -1, M_OFF, '0);
         measure(vecs[v].name, 1'b1, vecs[v].e0, vecs[v].e1, vecs[v].e2, -1, M_OFF, '0);
      end

      // SYNC fade: triangle 0,3,...,12,...,0, each value two periods
      mode = M_SYNC;
      measure("sync settle", 1'b0, 0, 0, 0, -1, M_OFF, '0);
      for (int n = 0; n < 20; n++) begin
         s   = n / STEP_PERIODS;
         pos = s % (2 * NUM_STEPS);
         lvl = (pos <= NUM_STEPS) ? pos : (2 * NUM_STEPS - pos);
         d   = lvl * UNIT;
         measure($sformatf("sync p%0d", n), 1'b1, d, d, d, -1, M_OFF, '0);
      end

      // PHASED: init at 0/UP, 2/UP, 3/DOWN then step together
      mode = M_PHASED;
      measure("phased settle", 1'b0, 0, 0, 0, -1, M_OFF, '0);
      measure("phased init a", 1'b1, 0, 6, 9, -1, M_OFF, '0);
      measure("phased init b", 1'b1, 0, 6, 9, -1, M_OFF, '0);
      measure("phased step1 a", 1'b1, 3, 9, 6, -1, M_OFF, '0);
      measure("phased step1 b", 1'b1, 3, 9, 6, -1, M_OFF, '0);
      measure("phased step2 a", 1'b1, 6, 12, 3, -1, M_OFF, '0);
      measure("phased step2 b", 1'b1, 6, 12, 3, -1, M_OFF, '0);

      // Mid-period SYNC->STATIC change must not disturb the running period
      mode = M_SYNC;
      measure("resync settle", 1'b0, 0, 0, 0, -1, M_OFF, '0);
      measure("resync p0", 1'b1, 0, 0, 0, -1, M_OFF, '0);
      measure("resync p1", 1'b1, 0, 0, 0, -1, M_OFF, '0);
      measure("resync p2", 1'b1, 3, 3, 3, -1, M_OFF, '0);
      measure("mid-period change", 1'b1, 3, 3, 3, 4, M_STATIC, {4'd12, 4'd5, 4'd0});
      measure("after change a", 1'b1, 0, 5, 12, -1, M_OFF, '0);
      measure("after change b", 1'b1, 0, 5, 12, -1, M_OFF, '0);

      // Freeze at cnt=7 for 30 cycles, then resume from cnt=7
      wait_start("freeze", ok);
      lows = '{0, 0, 0};
      for (int k = 0; k < 7; k++) begin
         if (k > 0) @(negedge clk);
         for (int c = 0; c < NUM_CH; c++) if (pwm_out[c] === 1'b0) lows[c]++;
      end
      check("pre-freeze ch1 low", lows[1] == 5, lows[1], 5);
      check("pre-freeze ch2 low", lows[2] == 7, lows[2], 7);
      enable = 1'b0;
      bad = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (pwm_out !== 3'b111 || period_start !== 1'b0) bad++;
      end
      check("frozen outputs inactive", bad == 0, bad, 0);
      enable = 1'b1;
      lows = '{0, 0, 0};
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         for (int c = 0; c < NUM_CH; c++) if (pwm_out[c] === 1'b0) lows[c]++;
         if (period_start !== 1'b0) bad++;
      end
      check("resume ch2 low cnt7..11", lows[2] == 5, lows[2], 5);
      check("resume ch1 low cnt7..11", lows[1] == 0, lows[1], 0);
      check("resume no early period_start", bad == 0, bad, 0);
      @(negedge clk);
      check("resume period_start after cnt 11", period_start === 1'b1, int'(period_start), 1);
      measure("after resume", 1'b1, 0, 5, 12, -1, M_OFF, '0);

      // Reset in the middle of a SYNC fade
      mode = M_SYNC;
      measure("prefade settle", 1'b0, 0, 0, 0, -1, M_OFF, '0);
      measure("prefade p0", 1'b1, 0, 0, 0, -1, M_OFF, '0);
      measure("prefade p1", 1'b1, 0, 0, 0, -1, M_OFF, '0);
      measure("prefade p2", 1'b1, 3, 3, 3, -1, M_OFF, '0);
      wait_start("mid reset", ok);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("mid reset pwm_out", pwm_out === 3'b111, int'(pwm_out), 7);
      check("mid reset period_start", period_start === 1'b0, int'(period_start), 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("period_start after mid reset", period_start === 1'b1, int'(period_start), 1);
      measure("post reset p0", 1'b1, 0, 0, 0, -1, M_OFF, '0);
      measure("post reset p1", 1'b1, 0, 0, 0, -1, M_OFF, '0);
      measure("post reset p2", 1'b1, 0, 0, 0, -1, M_OFF, '0);
      measure("post reset p3", 1'b1, 3, 3, 3, -1, M_OFF, '0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
